// File: rtl/operand_entry_datapath_pkg.sv
// ---------------------------------------------------------------------------
// operand_entry_datapath_pkg
// Shared constants for the calculator operand-entry datapath: keypad codes,
// seven-segment character codes and the entry FSM state encodings, plus two
// small key-classification helpers.
// No ports (package).
// ---------------------------------------------------------------------------
package operand_entry_datapath_pkg;

  // Keypad codes (0-9 are the digits themselves)
  localparam logic [4:0] KEY_ADD = 5'd10;
  localparam logic [4:0] KEY_SUB = 5'd11;
  localparam logic [4:0] KEY_DIV = 5'd13;
  localparam logic [4:0] KEY_EQ  = 5'd14;
  localparam logic [4:0] KEY_CLR = 5'd15;

  // Seven-segment character codes (0-9 show the digit)
  localparam logic [4:0] DISP_BLANK = 5'd15;
  localparam logic [4:0] DISP_MINUS = 5'd11;
  localparam logic [4:0] DISP_ERR   = 5'd14;
  localparam logic [4:0] DISP_F     = 5'd10;
  localparam logic [4:0] DISP_O     = 5'd0;

  // Entry FSM states
  localparam logic [1:0] S_A     = 2'd0;
  localparam logic [1:0] S_B     = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_ERR   = 2'd3;

  // A key in 0..9 is a digit
  function automatic logic is_digit(input logic [4:0] k);
    return k <= 5'd9;
  endfunction

  // Arithmetic operator keys are add, sub, mul and div (10..13)
  function automatic logic is_op(input logic [4:0] k);
    return (k >= KEY_ADD) && (k <= KEY_DIV);
  endfunction

endpackage

// File: rtl/operand_entry_datapath_if.sv
// ---------------------------------------------------------------------------
// operand_entry_datapath_if
// Bundles the keypad inputs, ALU error flag and all datapath outputs of the
// operand-entry block. Signal suffixes are from the datapath's point of view.
//   calc_active_i   calculator on/off switch
//   key_valid_i     one-cycle strobe, key_code_i is a new press
//   key_code_i      5-bit key code
//   err_in_i        ALU error level
//   operand_a_o/b_o signed operands (OPW bits)
//   operator_code_o latched operator key
//   operands_valid_o one-cycle pulse when A, op and B are complete
//   disp_codes_o    5-bit character code per display, [4:0] rightmost
// Modports: master (keypad / ALU side), slave (datapath).
// ---------------------------------------------------------------------------
interface operand_entry_datapath_if #(
  parameter int NUM_DISP = 8,
  parameter int OPW      = 8
);
  import operand_entry_datapath_pkg::*;

  logic                  calc_active_i;
  logic                  key_valid_i;
  logic [4:0]            key_code_i;
  logic                  err_in_i;
  logic [OPW-1:0]        operand_a_o;
  logic [OPW-1:0]        operand_b_o;
  logic [4:0]            operator_code_o;
  logic                  operands_valid_o;
  logic [5*NUM_DISP-1:0] disp_codes_o;

  modport master (
    output calc_active_i, key_valid_i, key_code_i, err_in_i,
    input  operand_a_o, operand_b_o, operator_code_o, operands_valid_o, disp_codes_o
  );

  modport slave (
    input  calc_active_i, key_valid_i, key_code_i, err_in_i,
    output operand_a_o, operand_b_o, operator_code_o, operands_valid_o, disp_codes_o
  );

endinterface

// File: rtl/operand_entry_datapath_bcd_operand_reg.sv
// ---------------------------------------------------------------------------
// operand_entry_datapath_bcd_operand_reg
// One signed operand under construction: sign, digit count, BCD digits and
// an incrementally maintained binary magnitude.
//   clk, rst        clock, async active-high reset
//   clear_i         zero the operand (applied before set/load in same cycle)
//   set_neg_i       set the sign bit
//   load_digit_i    append digit_i (ignored once DIGITS digits are held)
//   digit_i         BCD digit to append
//   sign_o, count_o, bcd_o   entry state for the display
//   value_o         two's complement operand (sign ? -mag : mag)
// ---------------------------------------------------------------------------
module operand_entry_datapath_bcd_operand_reg
  import operand_entry_datapath_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int OPW    = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear_i,
  input  logic                         set_neg_i,
  input  logic                         load_digit_i,
  input  logic [3:0]                   digit_i,
  output logic                         sign_o,
  output logic [$clog2(DIGITS+1)-1:0]  count_o,
  output logic [4*DIGITS-1:0]          bcd_o,
  output logic [OPW-1:0]               value_o
);

  localparam int CW = $clog2(DIGITS+1);

  logic              sign_q, sign_d;
  logic [CW-1:0]     count_q, count_d;
  logic [4*DIGITS-1:0] bcd_q, bcd_d;
  logic [OPW-1:0]    mag_q, mag_d;

  // Clear first so that a clear-and-load in one cycle starts a fresh operand
  always_comb begin
    sign_d  = clear_i ? 1'b0 : sign_q;
    count_d = clear_i ? '0   : count_q;
    bcd_d   = clear_i ? '0   : bcd_q;
    mag_d   = clear_i ? '0   : mag_q;
    if (set_neg_i) sign_d = 1'b1;
    if (load_digit_i && (count_d < CW'(DIGITS))) begin
      bcd_d      = bcd_d << 4;
      bcd_d[3:0] = digit_i;
      // mag*10 + d as shifts keeps the multiplier out of the datapath
      mag_d      = (mag_d << 3) + (mag_d << 1) + {{(OPW-4){1'b0}}, digit_i};
      count_d    = count_d + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q  <= 1'b0;
      count_q <= '0;
      bcd_q   <= '0;
      mag_q   <= '0;
    end else begin
      sign_q  <= sign_d;
      count_q <= count_d;
      bcd_q   <= bcd_d;
      mag_q   <= mag_d;
    end
  end

  assign sign_o  = sign_q;
  assign count_o = count_q;
  assign bcd_o   = bcd_q;
  assign value_o = sign_q ? -mag_q : mag_q;

endmodule

// File: rtl/operand_entry_datapath.sv
// ---------------------------------------------------------------------------
// operand_entry_datapath
// Keypad-entry datapath: builds signed BCD operands A and B plus an operator
// from debounced key codes, pulses operands_valid on equals, captures ALU
// errors and drives NUM_DISP seven-segment character codes.
//   clk, rst   clock, async active-high reset
//   bus        operand_entry_datapath_if.slave (keys, error, outputs)
// ---------------------------------------------------------------------------
module operand_entry_datapath
  import operand_entry_datapath_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int NUM_DISP = 8,
  parameter int OPW      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  operand_entry_datapath_if.slave bus
);

  localparam int CW = $clog2(DIGITS+1);

  logic [1:0] state_q, state_d;
  logic [4:0] opCode_q, opCode_d;
  logic       validPulse_q, validPulse_d;
  logic [NUM_DISP-1:0][4:0] dispCodes_q, dispCodes_d;

  logic [4:0] key;
  logic aClear, aSetNeg, aLoad, bClear, bSetNeg, bLoad;
  logic aSign, bSign;
  logic [CW-1:0] aCount, bCount;
  logic [4*DIGITS-1:0] aBcd, bBcd;

  assign key = bus.key_code_i;

  operand_entry_datapath_bcd_operand_reg #(.DIGITS(DIGITS), .OPW(OPW)) u_opA (
    .clk(clk), .rst(rst), .clear_i(aClear), .set_neg_i(aSetNeg),
    .load_digit_i(aLoad), .digit_i(key[3:0]), .sign_o(aSign),
    .count_o(aCount), .bcd_o(aBcd), .value_o(bus.operand_a_o)
  );

  operand_entry_datapath_bcd_operand_reg #(.DIGITS(DIGITS), .OPW(OPW)) u_opB (
    .clk(clk), .rst(rst), .clear_i(bClear), .set_neg_i(bSetNeg),
    .load_digit_i(bLoad), .digit_i(key[3:0]), .sign_o(bSign),
    .count_o(bCount), .bcd_o(bBcd), .value_o(bus.operand_b_o)
  );

  // Entry FSM: power switch beats error, error beats clear, clear beats keys.
  // Operand control strobes are decoded here; full-operand digit dropping is
  // left to the operand register.
  always_comb begin
    state_d      = state_q;
    opCode_d     = opCode_q;
    validPulse_d = 1'b0;
    aClear = 1'b0; aSetNeg = 1'b0; aLoad = 1'b0;
    bClear = 1'b0; bSetNeg = 1'b0; bLoad = 1'b0;
    if (!bus.calc_active_i) begin
      state_d = S_A; aClear = 1'b1; bClear = 1'b1; opCode_d = '0;
    end else if (bus.err_in_i) begin
      state_d = S_ERR;
    end else if (bus.key_valid_i) begin
      if (key == KEY_CLR) begin
        state_d = S_A; aClear = 1'b1; bClear = 1'b1; opCode_d = '0;
      end else begin
        case (state_q)
          S_A: begin
            if (is_digit(key)) aLoad = 1'b1;
            else if (key == KEY_SUB && aCount == '0 && !aSign) aSetNeg = 1'b1;
            else if (is_op(key) && aCount != '0) begin
              opCode_d = key;
              state_d  = S_B;
            end
          end
          S_B: begin
            if (is_digit(key)) bLoad = 1'b1;
            else if (key == KEY_SUB && bCount == '0 && !bSign) bSetNeg = 1'b1;
            else if (key == KEY_EQ && bCount != '0) begin
              state_d      = S_READY;
              validPulse_d = 1'b1;
            end
          end
          S_READY: begin
            // A new number starts a fresh calculation with this key as A
            if (is_digit(key)) begin
              aClear = 1'b1; bClear = 1'b1; aLoad = 1'b1; state_d = S_A;
            end else if (key == KEY_SUB) begin
              aClear = 1'b1; bClear = 1'b1; aSetNeg = 1'b1; state_d = S_A;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Display: right-justified digits of the operand being shown, '-' just left
  // of the most significant digit, blanks elsewhere. B is shown from S_B on,
  // so it reads blank until its first digit or sign arrives.
  always_comb begin
    logic              selSign;
    logic [CW-1:0]     selCount;
    logic [4*DIGITS-1:0] selBcd;
    selSign  = (state_q == S_A) ? aSign  : bSign;
    selCount = (state_q == S_A) ? aCount : bCount;
    selBcd   = (state_q == S_A) ? aBcd   : bBcd;
    for (int p = 0; p < NUM_DISP; p++) dispCodes_d[p] = DISP_BLANK;
    if (!bus.calc_active_i) begin
      dispCodes_d[0] = DISP_F;
      dispCodes_d[1] = DISP_F;
      dispCodes_d[2] = DISP_O;
    end else if (state_q == S_ERR) begin
      for (int p = 0; p < NUM_DISP; p++) dispCodes_d[p] = DISP_ERR;
    end else begin
      for (int p = 0; p < DIGITS; p++)
        if (p < int'(selCount)) dispCodes_d[p] = {1'b0, selBcd[4*p +: 4]};
      for (int p = 0; p < NUM_DISP; p++)
        if (selSign && p == int'(selCount)) dispCodes_d[p] = DISP_MINUS;
    end
  end

  // FSM, operator, valid pulse and display registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_A;
      opCode_q     <= '0;
      validPulse_q <= 1'b0;
      for (int p = 0; p < NUM_DISP; p++) dispCodes_q[p] <= DISP_BLANK;
    end else begin
      state_q      <= state_d;
      opCode_q     <= opCode_d;
      validPulse_q <= validPulse_d;
      dispCodes_q  <= dispCodes_d;
    end
  end

  assign bus.operator_code_o  = opCode_q;
  assign bus.operands_valid_o = validPulse_q;
  assign bus.disp_codes_o     = dispCodes_q;

endmodule

// File: tb/tb_operand_entry_datapath.sv
// ---------------------------------------------------------------------------
// tb_operand_entry_datapath
// Self-checking bench for operand_entry_datapath (DIGITS=2, NUM_DISP=8,
// OPW=8). A behavioural model holds each operand as an integer magnitude
// plus digit count and sign; displays are derived from it by decimal
// division. Each step drives one input cycle then one idle cycle.
// ---------------------------------------------------------------------------
module tb_operand_entry_datapath;

  localparam int DIGITS   = 2;
  localparam int NUM_DISP = 8;
  localparam int OPW      = 8;

  typedef enum {M_A, M_B, M_READY, M_ERR} modelMode_t;

  logic clk;
  logic rst;

  int testCount = 0;
  int failCount = 0;

  // Reference model state
  modelMode_t mMode;
  int         mMag [2];
  int         mCnt [2];
  bit         mNeg [2];
  int         mOp;
  bit         mValid;
  bit         mActive;

  operand_entry_datapath_if #(.NUM_DISP(NUM_DISP), .OPW(OPW)) bus ();

  operand_entry_datapath #(.DIGITS(DIGITS), .NUM_DISP(NUM_DISP), .OPW(OPW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running clock, period 10
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point for every check in the bench
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic void clearOperands();
    for (int i = 0; i < 2; i++) begin
      mMag[i] = 0; mCnt[i] = 0; mNeg[i] = 1'b0;
    end
  endfunction

  // Calculator behaviour for one clock with the given inputs
  function automatic void modelStep(input bit active, input bit err,
                                    input bit kv, input int k);
    int x;
    mValid  = 1'b0;
    mActive = active;
    if (!active) begin
      clearOperands(); mOp = 0; mMode = M_A;
    end else if (err) begin
      mMode = M_ERR;
    end else if (kv) begin
      if (k == 15) begin
        clearOperands(); mOp = 0; mMode = M_A;
      end else if (mMode == M_A || mMode == M_B) begin
        x = (mMode == M_A) ? 0 : 1;
        if (k <= 9) begin
          if (mCnt[x] < DIGITS) begin
            mMag[x] = mMag[x] * 10 + k;
            mCnt[x]++;
          end
        end else if (k == 11 && mCnt[x] == 0 && !mNeg[x]) begin
          mNeg[x] = 1'b1;
        end else if (mMode == M_A && k >= 10 && k <= 13 && mCnt[0] >= 1) begin
          mOp = k; mMode = M_B;
        end else if (mMode == M_B && k == 14 && mCnt[1] >= 1) begin
          mMode = M_READY; mValid = 1'b1;
        end
      end else if (mMode == M_READY) begin
        if (k <= 9) begin
          clearOperands(); mMag[0] = k; mCnt[0] = 1; mMode = M_A;
        end else if (k == 11) begin
          clearOperands(); mNeg[0] = 1'b1; mMode = M_A;
        end
      end
    end
  endfunction

  function automatic logic [OPW-1:0] modelOperand(input int x);
    return OPW'(mNeg[x] ? -mMag[x] : mMag[x]);
  endfunction

  // Expected display contents, built from decimal digits of the magnitude
  function automatic logic [5*NUM_DISP-1:0] modelDisplay();
    logic [5*NUM_DISP-1:0] d;
    int x, m;
    for (int p = 0; p < NUM_DISP; p++) d[5*p +: 5] = 5'd15;
    if (!mActive) begin
      d[4:0] = 5'd10; d[9:5] = 5'd10; d[14:10] = 5'd0;
    end else if (mMode == M_ERR) begin
      for (int p = 0; p < NUM_DISP; p++) d[5*p +: 5] = 5'd14;
    end else begin
      x = (mMode == M_A) ? 0 : 1;
      m = mMag[x];
      for (int p = 0; p < mCnt[x]; p++) begin
        d[5*p +: 5] = 5'(m % 10);
        m = m / 10;
      end
      if (mNeg[x]) d[5*mCnt[x] +: 5] = 5'd11;
    end
    return d;
  endfunction

  // One input cycle (key strobe if kv) followed by one idle cycle; operands
  // are checked after the first, display and valid-low after the second.
  task automatic applyStimulus(input bit active, input bit err,
                               input bit kv, input int k);
    @(negedge clk);
    bus.calc_active_i = active;
    bus.err_in_i      = err;
    bus.key_valid_i   = kv;
    bus.key_code_i    = 5'(k);
    @(negedge clk);
    modelStep(active, err, kv, k);
    checkOutput("operand_a", 64'(bus.operand_a_o), 64'(modelOperand(0)));
    checkOutput("operand_b", 64'(bus.operand_b_o), 64'(modelOperand(1)));
    checkOutput("operator_code", 64'(bus.operator_code_o), 64'(mOp));
    checkOutput("operands_valid", 64'(bus.operands_valid_o), 64'(mValid));
    bus.key_valid_i = 1'b0;
    @(negedge clk);
    modelStep(active, err, 1'b0, 0);
    checkOutput("disp_codes", 64'(bus.disp_codes_o), 64'(modelDisplay()));
    checkOutput("valid_pulse_end", 64'(bus.operands_valid_o), 64'(mValid));
  endtask

  task automatic pressKeys(input int keys[$]);
    foreach (keys[i]) applyStimulus(1'b1, 1'b0, 1'b1, keys[i]);
  endtask

  initial begin
    int r, k;
    bit act, err;
    rst               = 1'b1;
    bus.calc_active_i = 1'b1;
    bus.err_in_i      = 1'b0;
    bus.key_valid_i   = 1'b0;
    bus.key_code_i    = 5'd0;
    mMode = M_A; clearOperands(); mOp = 0; mValid = 1'b0; mActive = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    checkOutput("reset_disp", 64'(bus.disp_codes_o), 64'(modelDisplay()));
    checkOutput("reset_disp_blank", 64'(bus.disp_codes_o[4:0]), 64'd15);
    checkOutput("reset_operand_a", 64'(bus.operand_a_o), 64'd0);
    checkOutput("reset_operand_b", 64'(bus.operand_b_o), 64'd0);
    checkOutput("reset_valid", 64'(bus.operands_valid_o), 64'd0);
    checkOutput("reset_operator", 64'(bus.operator_code_o), 64'd0);

    // Negative operand A: -42
    pressKeys('{11, 4, 2});
    checkOutput("neg42_operand_a", 64'(bus.operand_a_o), 64'h00D6);
    checkOutput("neg42_disp", 64'(bus.disp_codes_o[14:0]), 64'({5'd11, 5'd4, 5'd2}));
    pressKeys('{15});

    // Full calculation 42 * 7 =
    pressKeys('{4, 2, 12, 7, 14});
    checkOutput("mul_operator", 64'(bus.operator_code_o), 64'd12);
    checkOutput("mul_operand_b", 64'(bus.operand_b_o), 64'd7);
    pressKeys('{15});

    // Third digit dropped, equals in S_A ignored
    pressKeys('{4, 2, 5, 14});
    checkOutput("overflow_operand_a", 64'(bus.operand_a_o), 64'd42);

    // Error wins over a key in the same cycle; clear recovers
    applyStimulus(1'b1, 1'b1, 1'b1, 3);
    checkOutput("err_disp_msd", 64'(bus.disp_codes_o[39:35]), 64'd14);
    pressKeys('{15});

    // Power off in the middle of B, keys ignored, then power back on
    pressKeys('{9, 10, 3});
    applyStimulus(1'b0, 1'b0, 1'b1, 5);
    checkOutput("off_disp", 64'(bus.disp_codes_o[14:0]), 64'({5'd0, 5'd10, 5'd10}));
    applyStimulus(1'b1, 1'b0, 1'b0, 0);

    // Sign-only operand and sign then digits on B; READY restarts on digit/sub
    pressKeys('{11, 11, 6, 13, 11, 14, 0, 8, 14, 5, 12, 11, 1, 14, 11});

    // Randomized key sequences
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      k = $urandom_range(0, 9);
      else if (r < 75) k = $urandom_range(10, 13);
      else if (r < 90) k = 14;
      else             k = 15;
      err = ($urandom_range(0, 99) < 3);
      act = ($urandom_range(0, 99) >= 3);
      applyStimulus(act, err, ($urandom_range(0, 9) != 0), k);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
